if_stage: RTL

//  Fetch stage plus IF/ID pipeline register feeding the ID stage of the redirect pipeline.

---
 rtl/if_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
//
// Purpose:
//    Holds the fetch PC and drives the word address of a combinational
//    instruction ROM. Registers {pc+4, instruction, valid} into the IF/ID
//    register for the decode stage. Handles the load-use stall, the
//    redirect (flush) resolved in EX, and the syscall halt/resume handshake.
//
// Optional feature:
//    IF_PERF_CNT_EN - when defined, adds the fetch_cnt and bubble_cnt
//    performance counters. When it is not defined, both counters and their
//    ports are absent.
//
// Ports:
//    clk          in   1        system clock, rising edge
//    rst          in   1        asynchronous active-high reset
//    stall        in   1        hold PC and IF/ID this cycle
//    redirect_en  in   1        taken branch/jump resolved in EX
//    redirect_pc  in   32       redirect target (bits [1:0] ignored)
//    halt_req     in   1        enter HALT
//    go           in   1        resume from HALT
//    imem_addr    out  IMEM_AW  ROM word address = pc[IMEM_AW+1:2]
//    imem_data    in   32       ROM read data, same cycle
//    id_pc        out  32       pc+4 of the instruction in IF/ID
//    id_ir        out  32       instruction word in IF/ID
//    id_valid     out  1        IF/ID holds a real instruction
//    halted       out  1        state is HALT
//    pc_out       out  32       current fetch PC
//    fetch_cnt    out  32       normal fetches (IF_PERF_CNT_EN only)
//    bubble_cnt   out  32       bubble loads into IF/ID (IF_PERF_CNT_EN only)
module if_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          IMEM_AW  = 10,
   parameter logic [31:0] NOP_IR   = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               redirect_en,
   input  logic [31:0]        redirect_pc,
   input  logic               halt_req,
   input  logic               go,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_data,
   output logic [31:0]        id_pc,
   output logic [31:0]        id_ir,
   output logic               id_valid,
   output logic               halted,
   output logic [31:0]        pc_out
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]        fetch_cnt,
   output logic [31:0]        bubble_cnt
`endif
);

   typedef enum logic {S_RUN, S_HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_ir_q, id_ir_d;
   logic        id_valid_q, id_valid_d;
   logic        load_bubble;
   logic        do_fetch;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      id_pc_d     = id_pc_q;
      id_ir_d     = id_ir_q;
      id_valid_d  = id_valid_q;
      load_bubble = 1'b0;
      do_fetch    = 1'b0;

      case (state_q)
         S_RUN: begin
            if (halt_req) begin
               // PC stays put so that the resume fetches the same instruction.
               state_d     = S_HALT;
               load_bubble = 1'b1;
            end else if (redirect_en) begin
               // Redirect wins over stall: the stalled instruction is on the wrong path.
               pc_d        = redirect_pc & ~32'd3;
               load_bubble = 1'b1;
            end else if (!stall) begin
               do_fetch = 1'b1;
            end
         end
         S_HALT: begin
            load_bubble = 1'b1;
            if (go && !halt_req) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_RUN;
         end
      endcase

      if (load_bubble) begin
         // id_pc is left unchanged on a bubble.
         id_ir_d    = NOP_IR;
         id_valid_d = 1'b0;
      end else if (do_fetch) begin
         pc_d       = pc_plus4;
         id_pc_d    = pc_plus4;
         id_ir_d    = imem_data;
         id_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_RUN;
         pc_q       <= PC_RESET;
         id_pc_q    <= 32'd0;
         id_ir_q    <= NOP_IR;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         id_pc_q    <= id_pc_d;
         id_ir_q    <= id_ir_d;
         id_valid_q <= id_valid_d;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, bubble_cnt_q;

   // Stall cycles are counted as neither a fetch nor a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q  <= 32'd0;
         bubble_cnt_q <= 32'd0;
      end else begin
         if (do_fetch) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (load_bubble) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
         end
      end
   end

   assign fetch_cnt  = fetch_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

   assign imem_addr = pc_q[IMEM_AW+1:2];
   assign id_pc     = id_pc_q;
   assign id_ir     = id_ir_q;
   assign id_valid  = id_valid_q;
   assign halted    = (state_q == S_HALT);
   assign pc_out    = pc_q;

endmodule
